// File: rtl/el_t_pkg.sv
// Shared definitions for the replicating register bank: scrub FSM encoding,
// a constant log2 helper and the default scrub period.
package el_t_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPAIR = 2'd2
  } scrub_state_t;

  localparam int SCRUB_PERIOD_DEF = 256;

  // Ceiling log2 with a floor of 1 so a width derived from it is never zero.
  function automatic int el_t_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/el_t_maj.sv
// Purely combinational bitwise majority over IN_NUM replicas of DATA_W bits.
module el_t_maj #(
  parameter int IN_NUM = 3,
  parameter int DATA_W = 8
) (
  input  logic [IN_NUM*DATA_W-1:0] bus,
  output logic [DATA_W-1:0]        maj
);

  localparam int THRESH = (IN_NUM + 1) / 2;

  function automatic logic vote_bit(input logic [IN_NUM-1:0] v);
    int ones;
    ones = 0;
    for (int r = 0; r < IN_NUM; r++) ones += int'(v[r]);
    return ones >= THRESH;
  endfunction

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    logic [IN_NUM-1:0] col;
    for (genvar gr = 0; gr < IN_NUM; gr++) begin : g_col
      assign col[gr] = bus[gr*DATA_W + gi];
    end
    assign maj[gi] = vote_bit(col);
  end

endmodule

// File: rtl/el_t_rep.sv
// Replicating register bank with periodic majority scrub and repair counting.
// Optional fault-injection ports are enabled by defining EL_T_FAULT_INJ_EN.
module el_t_rep
  import el_t_pkg::*;
#(
  parameter int IN_NUM       = 3,
  parameter int DATA_W       = 8,
  parameter int SCRUB_PERIOD = SCRUB_PERIOD_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in,
`ifdef EL_T_FAULT_INJ_EN
  input  logic                            inj_stb,
  input  logic [el_t_log2(IN_NUM)-1:0]    inj_sel,
  input  logic [DATA_W-1:0]               inj_mask,
`endif
  output logic [IN_NUM*DATA_W-1:0]        out,
  output logic [DATA_W-1:0]               voted,
  output logic                            scrub_busy,
  output logic                            fault,
  output logic [CNT_W-1:0]                fault_cnt
);

  localparam int SEL_W = el_t_log2(IN_NUM);
  localparam int TMR_W = el_t_log2(SCRUB_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  scrub_state_t        state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg;
  logic [IN_NUM-1:0]   dirty_reg, dirty_next;
  logic [DATA_W-1:0]   voted_reg, maj_w;
  logic [DATA_W-1:0]   rep_reg [IN_NUM];
  logic [CNT_W-1:0]    fault_cnt_reg;
  logic [IN_NUM-1:0]   inj_hit;
  logic [DATA_W-1:0]   inj_mask_w;
  logic                inj_act;
  logic                repair_go;
  logic [31:0]         dirty_pop;
  logic [31:0]         cnt_sum;

`ifdef EL_T_FAULT_INJ_EN
  assign inj_act    = inj_stb;
  assign inj_mask_w = inj_mask;
  for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_inj
    // Out-of-range selects never match any replica and are dropped.
    assign inj_hit[gi] = inj_stb && (inj_sel == SEL_W'(gi));
  end
`else
  assign inj_act    = 1'b0;
  assign inj_mask_w = '0;
  assign inj_hit    = '0;
`endif

  el_t_maj #(.IN_NUM(IN_NUM), .DATA_W(DATA_W)) u_maj (
    .bus (out),
    .maj (maj_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    dirty_next = '0;
    for (int r = 0; r < IN_NUM; r++) dirty_next[r] = (rep_reg[r] != voted_reg);
  end

  always_comb begin
    state_next = state_reg;
    if (in_valid) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (timer_reg == TMR_LAST) state_next = ST_CHECK;
        ST_CHECK:  state_next = (dirty_next != '0) ? ST_REPAIR : ST_IDLE;
        ST_REPAIR: state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // A load or an injection in the REPAIR cycle cancels the repair entirely.
  always_comb begin
    scrub_busy = (state_reg != ST_IDLE);
    repair_go  = (state_reg == ST_REPAIR) && !in_valid && !inj_act;
    fault      = repair_go;
  end

  always_ff @(posedge clk) begin
    if (rst || in_valid || state_reg != ST_IDLE || timer_reg == TMR_LAST)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_reg <= '0;
      voted_reg <= '0;
    end else begin
      voted_reg <= maj_w;
      if (state_reg == ST_CHECK) dirty_reg <= dirty_next;
    end
  end

  always_comb begin
    dirty_pop = '0;
    for (int r = 0; r < IN_NUM; r++) dirty_pop += 32'(dirty_reg[r]);
    cnt_sum = 32'(fault_cnt_reg) + dirty_pop;
  end

  always_ff @(posedge clk) begin
    if (rst)
      fault_cnt_reg <= '0;
    else if (repair_go)
      fault_cnt_reg <= (cnt_sum > 32'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_rep
    always_ff @(posedge clk) begin
      if (rst)
        rep_reg[gi] <= '0;
      else if (in_valid)
        rep_reg[gi] <= in;
      else if (inj_hit[gi])
        rep_reg[gi] <= rep_reg[gi] ^ inj_mask_w;
      else if (repair_go && dirty_reg[gi])
        rep_reg[gi] <= voted_reg;
    end
    assign out[gi*DATA_W +: DATA_W] = rep_reg[gi];
  end

  assign voted     = voted_reg;
  assign fault_cnt = fault_cnt_reg;

endmodule

// File: doc/el_t_rep.md
# el_t_rep

Replicating register bank. It is the source side of the triple-redundant path whose sink is the majority voter. It captures a DATA_W-bit word into IN_NUM independent replica registers and drives them out as a flat bus. A periodic scrub engine re-votes the replicas and rewrites any replica that disagrees with the bitwise majority, counting repaired faults.

## Interface
- IN_NUM, 3, replica count; odd, ≥3
- DATA_W, 8, word width per replica
- SCRUB_PERIOD, 256, cycles between scrub passes; ≥4
- CNT_W, 16, width of the fault counter
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  load strobe
- in  in  DATA_W  word to replicate
- out  out  IN_NUM*DATA_W  replica r occupies bits [r*DATA_W +: DATA_W]
- voted  out  DATA_W  registered bitwise majority of the replicas
- scrub_busy  out  1  high in CHECK and REPAIR states
- fault  out  1  one-cycle pulse when a repair is written
- fault_cnt  out  CNT_W  saturating count of repaired replicas

## Operation
- Majority per bit: a bit is 1 when at least (IN_NUM+1)/2 replicas hold 1.
- Load: when in_valid=1, every replica takes `in` on that edge. The period timer restarts at 0, and any scrub pass in progress is aborted to IDLE with no repair written.
- FSM states:
  - IDLE: the timer counts 0..SCRUB_PERIOD-1; at terminal count go to CHECK.
  - CHECK (1 cycle): compare each replica with `voted` and latch a dirty mask of IN_NUM bits. If the mask is nonzero go to REPAIR, otherwise go to IDLE.
  - REPAIR (1 cycle): every dirty replica is written with `voted`, then the FSM returns to IDLE.
- fault_cnt increments by popcount(dirty mask) in REPAIR and saturates at all-ones. fault pulses in REPAIR.
- Priority: in_valid beats every scrub action in the same cycle.

## Timing
- Reset values: all replicas 0, voted 0, scrub_busy 0, fault 0, fault_cnt 0, FSM IDLE, timer 0.
- Load latency: out reflects `in` 1 cycle after the in_valid edge. voted reflects it 2 cycles after that edge.
- Scrub cadence: CHECK is entered SCRUB_PERIOD cycles after the last load or pass. A repair lands 2 cycles after CHECK is entered.
- Asserting rst mid-scrub returns the block to the reset state on the next edge, with no repair written.
- Back-to-back in_valid: each edge loads, and the scrub timer never expires.

## Configuration
- EL_T_FAULT_INJ_EN defined: adds these ports:
  - inj_stb in 1
  - inj_sel in log2(IN_NUM) bits (sized with a constant function, not $clog2)
  - inj_mask in DATA_W
- When inj_stb=1, replica inj_sel is XORed with inj_mask on that edge.
- Priority order is in_valid > inj_stb > repair.
- inj_sel ≥ IN_NUM is ignored.
- Undefined: the ports are absent and replicas change only by load or repair.

## Structure
- Shared package (el_t_pkg): FSM state encodings, the log2 constant function, and the default SCRUB_PERIOD.
- One sub-module, el_t_maj: purely combinational bitwise majority over an IN_NUM×DATA_W bus. It is instantiated once, and its result is registered into voted.

## Test plan
- Reset: drive rst for 2 cycles → all outputs 0, scrub_busy 0.
- Load: in=0xA5 with in_valid for 1 cycle → out = 0xA5 in all 3 slots after 1 cycle; voted=0xA5 after 2 cycles; no fault over 300 idle cycles.
- Single upset (EL_T_FAULT_INJ_EN): after loading 0x3C, inject inj_sel=1, inj_mask=0x01 → replica 1 = 0x3D and voted stays 0x3C. At the next scrub, replica 1 = 0x3C, fault pulses once, and fault_cnt=1.
- Load during REPAIR: inject a fault, then assert in_valid with in=0x00 in the REPAIR cycle → all replicas 0x00 and fault_cnt unchanged.
- Saturation: CNT_W=2, five repair passes → fault_cnt holds at 3.
- Reset mid-CHECK: assert rst during scrub_busy → the next cycle shows reset values and no fault pulse.
